// File: rtl/uc_master_pkg.sv
// Shared FSM encoding, AXI burst/size constants and the alignment helper
// for the uncached-master AR issue path.
package uc_master_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    LOOKUP  = 2'd2,
    ISSUE   = 2'd3
  } ar_state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_1B = 3'd0;
  localparam logic [2:0] SIZE_2B = 3'd1;
  localparam logic [2:0] SIZE_4B = 3'd2;
  localparam logic [2:0] SIZE_8B = 3'd3;

  // Only the low 7 address bits matter: the widest AXI beat is 128 bytes.
  function automatic logic addr_aligned(input logic [6:0] addr_lo, input logic [2:0] size);
    logic [7:0] mask;
    mask = (8'd1 << size) - 8'd1;
    return (addr_lo & mask[6:0]) == 7'd0;
  endfunction

endpackage

// File: rtl/ar_issue_uc_master_if.sv
// AXI read-address channel bundle between the AR issue master and the fabric.
interface ar_issue_uc_master_if #(
  parameter int IDW        = 4,
  parameter int ADDR_WIDTH = 64
);
  logic [IDW-1:0]        m_axi_arid;
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]            m_axi_arlen;
  logic [2:0]            m_axi_arsize;
  logic [1:0]            m_axi_arburst;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;

  modport master (
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_arready
  );

  modport slave (
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_arready
  );
endinterface

// File: rtl/outstanding_counter_uc_master.sv
// Tracks reads issued but not yet completed: +1 per AR handshake, -1 per RLAST,
// clamped at zero (a stray RLAST never wraps it).
module outstanding_counter_uc_master #(
  parameter  int MAX_OUTSTANDING = 16,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !dec && count_q != CW'(MAX_OUTSTANDING)) begin
      count_d = count_q + CW'(1);
    end else if (dec && !inc && count_q != '0) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ar_issue_uc_master.sv
// Pops a descriptor ID, looks up its fields and issues one AXI read per descriptor.
// Define UC_AR_ALIGN_CHECK_EN to drop descriptors whose address is misaligned to their beat size.
module ar_issue_uc_master
  import uc_master_pkg::*;
#(
  parameter  int MAX_DESC        = 16,
  parameter  int ADDR_WIDTH      = 64,
  parameter  int MAX_OUTSTANDING = 16,
  localparam int IDW             = $clog2(MAX_DESC),
  localparam int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  axi_aclk,
  input  logic                  axi_areset,
  input  logic                  read_request_en,
  input  logic [IDW-1:0]        read_request_id,
  output logic                  rd_desc_allocation_in_progress,
  output logic                  arnext,
  output logic [IDW-1:0]        desc_idx,
  input  logic [ADDR_WIDTH-1:0] desc_addr,
  input  logic [7:0]            desc_len,
  input  logic [2:0]            desc_size,
  input  logic [1:0]            desc_burst,
  ar_issue_uc_master_if.master  ar,
  input  logic                  rlast_hs,
  output logic                  align_err,
  output logic [IDW-1:0]        align_err_id
);

  ar_state_e             state_q, state_d;
  logic [IDW-1:0]        id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic                  arnext_q, arnext_d;
  logic [CW-1:0]         outstanding;
  logic                  ar_hs;
  logic                  slot_free;
  logic                  misaligned;

  assign ar_hs     = (state_q == ISSUE) && ar.m_axi_arready;
  assign slot_free = outstanding < CW'(MAX_OUTSTANDING);

  outstanding_counter_uc_master #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_outstanding (
    .clk  (axi_aclk),
    .rst  (axi_areset),
    .inc  (ar_hs),
    .dec  (rlast_hs),
    .count(outstanding)
  );

`ifdef UC_AR_ALIGN_CHECK_EN
  logic           align_err_q, align_err_d;
  logic [IDW-1:0] align_err_id_q, align_err_id_d;

  assign misaligned = !addr_aligned(desc_addr[6:0], desc_size);

  always_comb begin
    align_err_d    = (state_q == LOOKUP) && misaligned;
    align_err_id_d = align_err_d ? id_q : align_err_id_q;
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      align_err_q    <= 1'b0;
      align_err_id_q <= '0;
    end else begin
      align_err_q    <= align_err_d;
      align_err_id_q <= align_err_id_d;
    end
  end

  assign align_err    = align_err_q;
  assign align_err_id = align_err_id_q;
`else
  assign misaligned   = 1'b0;
  assign align_err    = 1'b0;
  assign align_err_id = '0;
`endif

  // A dropped (misaligned) descriptor retires straight from LOOKUP without a slot.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    addr_d   = addr_q;
    len_d    = len_q;
    size_d   = size_q;
    burst_d  = burst_q;
    arnext_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (read_request_en) state_d = CAPTURE;
      end
      CAPTURE: begin
        id_d    = read_request_id;
        state_d = LOOKUP;
      end
      LOOKUP: begin
        addr_d  = desc_addr;
        len_d   = desc_len;
        size_d  = desc_size;
        burst_d = desc_burst;
        if (misaligned) begin
          arnext_d = 1'b1;
          state_d  = IDLE;
        end else if (slot_free) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (ar.m_axi_arready) begin
          arnext_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state_q  <= IDLE;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      arnext_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      size_q   <= size_d;
      burst_q  <= burst_d;
      arnext_q <= arnext_d;
    end
  end

  // Busy also covers the arnext cycle so the allocator cannot pop before retirement is seen.
  assign rd_desc_allocation_in_progress = (state_q != IDLE) || arnext_q;
  assign arnext            = arnext_q;
  assign desc_idx          = id_q;
  assign ar.m_axi_arid     = id_q;
  assign ar.m_axi_araddr   = addr_q;
  assign ar.m_axi_arlen    = len_q;
  assign ar.m_axi_arsize   = size_q;
  assign ar.m_axi_arburst  = burst_q;
  assign ar.m_axi_arvalid  = (state_q == ISSUE);

endmodule

// File: tb/tb_ar_issue_uc_master.sv
// Self-checking bench for ar_issue_uc_master: transaction-level model plus directed literal checks.
// Honours UC_AR_ALIGN_CHECK_EN the same way the design does.
module tb_ar_issue_uc_master;
  import uc_master_pkg::*;

  localparam int MAX_DESC = 16;
  localparam int AW       = 64;
  localparam int MAXO     = 2;
  localparam int IDW      = 4;

  logic           clk     = 1'b0;
  logic           rst     = 1'b1;
  logic           en      = 1'b0;
  logic           arready = 1'b0;
  logic           rlast   = 1'b0;
  logic [IDW-1:0] req_id  = '0;

  logic           busy, arnext, align_err;
  logic [IDW-1:0] desc_idx, align_err_id;
  logic [AW-1:0]  desc_addr;
  logic [7:0]     desc_len;
  logic [2:0]     desc_size;
  logic [1:0]     desc_burst;

  logic [AW-1:0]  t_addr  [MAX_DESC];
  logic [7:0]     t_len   [MAX_DESC];
  logic [2:0]     t_size  [MAX_DESC];
  logic [1:0]     t_burst [MAX_DESC];
  logic [2:0]     sizes   [4];
  logic [1:0]     bursts  [3];

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model: m_stage 0 = no request, 1 = ID due this cycle, 2 = fetching fields, 3 = offering AR
  int             m_stage = 0;
  int             m_out   = 0;
  logic [IDW-1:0] m_id    = '0;
  logic [IDW-1:0] m_alid  = '0;
  logic [AW-1:0]  m_addr  = '0;
  logic [7:0]     m_len   = '0;
  logic [2:0]     m_size  = '0;
  logic [1:0]     m_burst = '0;
  logic           m_arnext = 1'b0;
  logic           m_alerr  = 1'b0;
  logic           m_hs, m_slot, m_mis;

  always #5 clk = ~clk;

  ar_issue_uc_master_if #(.IDW(IDW), .ADDR_WIDTH(AW)) ar_if ();
  assign ar_if.m_axi_arready = arready;

  assign desc_addr  = t_addr[desc_idx];
  assign desc_len   = t_len[desc_idx];
  assign desc_size  = t_size[desc_idx];
  assign desc_burst = t_burst[desc_idx];

  ar_issue_uc_master #(
    .MAX_DESC(MAX_DESC),
    .ADDR_WIDTH(AW),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .axi_aclk                      (clk),
    .axi_areset                    (rst),
    .read_request_en               (en),
    .read_request_id               (req_id),
    .rd_desc_allocation_in_progress(busy),
    .arnext                        (arnext),
    .desc_idx                      (desc_idx),
    .desc_addr                     (desc_addr),
    .desc_len                      (desc_len),
    .desc_size                     (desc_size),
    .desc_burst                    (desc_burst),
    .ar                            (ar_if),
    .rlast_hs                      (rlast),
    .align_err                     (align_err),
    .align_err_id                  (align_err_id)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [IDW-1:0] id,
                               input logic rdy, input logic rl);
    @(posedge clk);
    #1;
    rst     = r;
    en      = e;
    req_id  = id;
    arready = rdy;
    rlast   = rl;
    @(negedge clk);
  endtask

  task automatic doRequest(input logic [IDW-1:0] id, input logic rl_at_hs);
    applyStimulus(0, 1, '0, 0, 0);
    applyStimulus(0, 0, id, 0, 0);
    applyStimulus(0, 0, ~id, 0, 0);
    applyStimulus(0, 0, ~id, 1, rl_at_hs);
    checkOutput("req_arvalid", 64'(ar_if.m_axi_arvalid), 64'd1);
    checkOutput("req_arid", 64'(ar_if.m_axi_arid), 64'(id));
    applyStimulus(0, 0, ~id, 0, 0);
    checkOutput("req_arnext", 64'(arnext), 64'd1);
  endtask

  // Model update on every rising edge from the bench-driven inputs only.
  always @(posedge clk) begin
    if (rst) begin
      m_stage = 0; m_out = 0; m_id = '0; m_alid = '0;
      m_addr = '0; m_len = '0; m_size = '0; m_burst = '0;
      m_arnext = 1'b0; m_alerr = 1'b0;
    end else begin
      m_hs     = (m_stage == 3) && arready;
      m_slot   = (m_out < MAXO);
      m_arnext = m_hs;
      m_alerr  = 1'b0;
      m_out    = m_out + (m_hs ? 1 : 0) - (rlast ? 1 : 0);
      if (m_out < 0) m_out = 0;
      case (m_stage)
        0: if (en) m_stage = 1;
        1: begin
          m_id    = req_id;
          m_stage = 2;
        end
        2: begin
          m_addr  = t_addr[m_id];
          m_len   = t_len[m_id];
          m_size  = t_size[m_id];
          m_burst = t_burst[m_id];
`ifdef UC_AR_ALIGN_CHECK_EN
          m_mis = (t_addr[m_id] % (64'd1 << t_size[m_id])) != 64'd0;
`else
          m_mis = 1'b0;
`endif
          if (m_mis) begin
            m_alerr  = 1'b1;
            m_alid   = m_id;
            m_arnext = 1'b1;
            m_stage  = 0;
          end else if (m_slot) begin
            m_stage = 3;
          end
        end
        3: if (arready) m_stage = 0;
        default: m_stage = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("m_arvalid", 64'(ar_if.m_axi_arvalid), 64'(m_stage == 3));
      checkOutput("m_arnext", 64'(arnext), 64'(m_arnext));
      checkOutput("m_busy", 64'(busy), 64'((m_stage != 0) || m_arnext));
      checkOutput("m_align_err", 64'(align_err), 64'(m_alerr));
      checkOutput("m_align_err_id", 64'(align_err_id), 64'(m_alid));
      if (m_stage >= 2) checkOutput("m_desc_idx", 64'(desc_idx), 64'(m_id));
      if (m_stage == 3) begin
        checkOutput("m_arid", 64'(ar_if.m_axi_arid), 64'(m_id));
        checkOutput("m_araddr", ar_if.m_axi_araddr, m_addr);
        checkOutput("m_arlen", 64'(ar_if.m_axi_arlen), 64'(m_len));
        checkOutput("m_arsize", 64'(ar_if.m_axi_arsize), 64'(m_size));
        checkOutput("m_arburst", 64'(ar_if.m_axi_arburst), 64'(m_burst));
      end
    end
  end

  initial begin
    sizes  = '{SIZE_1B, SIZE_2B, SIZE_4B, SIZE_8B};
    bursts = '{BURST_FIXED, BURST_INCR, BURST_WRAP};
    for (int i = 0; i < MAX_DESC; i++) begin
      t_addr[i]  = 64'h2000 + 64'(i) * 64'h40;
      t_len[i]   = 8'(i * 3);
      t_size[i]  = sizes[i % 4];
      t_burst[i] = bursts[i % 3];
    end
    t_addr[3] = 64'h1000; t_len[3] = 8'd7; t_size[3] = SIZE_8B;
    t_addr[5] = 64'h1004; t_len[5] = 8'd1; t_size[5] = SIZE_8B;

    $display("[TB] start");
    applyStimulus(1, 0, '0, 0, 0);
    checkOutput("rst_arvalid", 64'(ar_if.m_axi_arvalid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_arnext", 64'(arnext), 64'd0);
    checkOutput("rst_align_err", 64'(align_err), 64'd0);
    checkOutput("rst_desc_idx", 64'(desc_idx), 64'd0);
    chk_en = 1'b1;
    applyStimulus(0, 0, '0, 0, 0);

    // Basic issue, id 3 @0x1000 len 7 size 3, arready held high
    applyStimulus(0, 1, '0, 1, 0);
    checkOutput("t0_busy", 64'(busy), 64'd0);
    applyStimulus(0, 0, 4'd3, 1, 0);
    checkOutput("t1_busy", 64'(busy), 64'd1);
    checkOutput("t1_arvalid", 64'(ar_if.m_axi_arvalid), 64'd0);
    applyStimulus(0, 0, 4'd9, 1, 0);
    checkOutput("t2_desc_idx", 64'(desc_idx), 64'd3);
    checkOutput("t2_arvalid", 64'(ar_if.m_axi_arvalid), 64'd0);
    applyStimulus(0, 0, 4'd9, 1, 0);
    checkOutput("t3_arvalid", 64'(ar_if.m_axi_arvalid), 64'd1);
    checkOutput("t3_arid", 64'(ar_if.m_axi_arid), 64'd3);
    checkOutput("t3_araddr", ar_if.m_axi_araddr, 64'h1000);
    checkOutput("t3_arlen", 64'(ar_if.m_axi_arlen), 64'd7);
    checkOutput("t3_arsize", 64'(ar_if.m_axi_arsize), 64'd3);
    checkOutput("t3_arnext", 64'(arnext), 64'd0);
    applyStimulus(0, 0, 4'd9, 0, 0);
    checkOutput("t4_arnext", 64'(arnext), 64'd1);
    checkOutput("t4_busy", 64'(busy), 64'd1);
    checkOutput("t4_arvalid", 64'(ar_if.m_axi_arvalid), 64'd0);
    applyStimulus(0, 0, 4'd9, 0, 0);
    checkOutput("t5_arnext", 64'(arnext), 64'd0);
    checkOutput("t5_busy", 64'(busy), 64'd0);
    // Retire it, then a stray RLAST at zero must not wrap
    applyStimulus(0, 0, '0, 0, 1);
    applyStimulus(0, 0, '0, 0, 1);
    applyStimulus(0, 0, '0, 0, 0);

    // arready low for 5 cycles, en pulses while busy are ignored; id 6 @0x2180 len 18
    applyStimulus(0, 1, '0, 0, 0);
    applyStimulus(0, 0, 4'd6, 0, 0);
    applyStimulus(0, 0, '0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 1, 4'd2, 0, 0);
      checkOutput("stall_arvalid", 64'(ar_if.m_axi_arvalid), 64'd1);
      checkOutput("stall_araddr", ar_if.m_axi_araddr, 64'h2180);
      checkOutput("stall_arlen", 64'(ar_if.m_axi_arlen), 64'd18);
      checkOutput("stall_arnext", 64'(arnext), 64'd0);
    end
    applyStimulus(0, 0, '0, 1, 0);
    checkOutput("stall_hs_arvalid", 64'(ar_if.m_axi_arvalid), 64'd1);
    checkOutput("stall_hs_arnext", 64'(arnext), 64'd0);
    applyStimulus(0, 0, '0, 0, 0);
    checkOutput("stall_arnext_pulse", 64'(arnext), 64'd1);
    applyStimulus(0, 0, '0, 0, 0);
    checkOutput("stall_arnext_done", 64'(arnext), 64'd0);
    applyStimulus(0, 0, '0, 0, 1);
    applyStimulus(0, 0, '0, 0, 0);

    // Fill both slots, third request waits in lookup until an RLAST
    doRequest(4'd1, 1'b0);
    doRequest(4'd2, 1'b0);
    applyStimulus(0, 1, '0, 0, 0);
    applyStimulus(0, 0, 4'd4, 0, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, '0, 1, 0);
      checkOutput("throttle_arvalid", 64'(ar_if.m_axi_arvalid), 64'd0);
      checkOutput("throttle_busy", 64'(busy), 64'd1);
    end
    applyStimulus(0, 0, '0, 0, 1);
    checkOutput("throttle_r0_arvalid", 64'(ar_if.m_axi_arvalid), 64'd0);
    applyStimulus(0, 0, '0, 0, 0);
    checkOutput("throttle_r1_arvalid", 64'(ar_if.m_axi_arvalid), 64'd0);
    applyStimulus(0, 0, '0, 1, 0);
    checkOutput("throttle_r2_arvalid", 64'(ar_if.m_axi_arvalid), 64'd1);
    checkOutput("throttle_r2_arid", 64'(ar_if.m_axi_arid), 64'd4);
    applyStimulus(0, 0, '0, 0, 0);

    // Count 2 -> 1, then handshake and RLAST together keep it at 1
    applyStimulus(0, 0, '0, 0, 1);
    doRequest(4'd7, 1'b1);
    doRequest(4'd8, 1'b0);
    applyStimulus(0, 1, '0, 0, 0);
    applyStimulus(0, 0, 4'd9, 0, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, '0, 1, 0);
      checkOutput("both_stall_arvalid", 64'(ar_if.m_axi_arvalid), 64'd0);
    end
    applyStimulus(0, 0, '0, 1, 1);
    applyStimulus(0, 0, '0, 1, 0);
    applyStimulus(0, 0, '0, 1, 0);
    checkOutput("both_issue_arid", 64'(ar_if.m_axi_arid), 64'd9);
    applyStimulus(0, 0, '0, 0, 1);
    applyStimulus(0, 0, '0, 0, 1);
    applyStimulus(0, 0, '0, 0, 0);

    // Misaligned descriptor id 5: 0x1004 with 8-byte beats
    applyStimulus(0, 1, '0, 0, 0);
    applyStimulus(0, 0, 4'd5, 0, 0);
    applyStimulus(0, 0, '0, 0, 0);
`ifdef UC_AR_ALIGN_CHECK_EN
    applyStimulus(0, 0, '0, 1, 0);
    checkOutput("mis_align_err", 64'(align_err), 64'd1);
    checkOutput("mis_align_err_id", 64'(align_err_id), 64'd5);
    checkOutput("mis_arvalid", 64'(ar_if.m_axi_arvalid), 64'd0);
    checkOutput("mis_arnext", 64'(arnext), 64'd1);
    applyStimulus(0, 0, '0, 0, 0);
    checkOutput("mis_align_err_done", 64'(align_err), 64'd0);
    checkOutput("mis_busy_done", 64'(busy), 64'd0);
`else
    applyStimulus(0, 0, '0, 1, 0);
    checkOutput("mis_arvalid", 64'(ar_if.m_axi_arvalid), 64'd1);
    checkOutput("mis_araddr", ar_if.m_axi_araddr, 64'h1004);
    checkOutput("mis_align_err", 64'(align_err), 64'd0);
    applyStimulus(0, 0, '0, 0, 0);
    checkOutput("mis_arnext", 64'(arnext), 64'd1);
    applyStimulus(0, 0, '0, 0, 1);
`endif
    applyStimulus(0, 0, '0, 0, 0);

    // Reset while AR is being offered, then a request right after reset
    applyStimulus(0, 1, '0, 0, 0);
    applyStimulus(0, 0, 4'd2, 0, 0);
    applyStimulus(0, 0, '0, 0, 0);
    applyStimulus(0, 0, '0, 0, 0);
    checkOutput("prerst_arvalid", 64'(ar_if.m_axi_arvalid), 64'd1);
    applyStimulus(1, 0, '0, 0, 0);
    checkOutput("inrst_arvalid", 64'(ar_if.m_axi_arvalid), 64'd1);
    applyStimulus(0, 1, '0, 0, 0);
    checkOutput("postrst_arvalid", 64'(ar_if.m_axi_arvalid), 64'd0);
    checkOutput("postrst_busy", 64'(busy), 64'd0);
    checkOutput("postrst_arnext", 64'(arnext), 64'd0);
    applyStimulus(0, 0, 4'd11, 0, 0);
    checkOutput("postrst_capture_busy", 64'(busy), 64'd1);
    applyStimulus(0, 0, '0, 0, 0);
    applyStimulus(0, 0, '0, 1, 0);
    checkOutput("postrst_arvalid_t3", 64'(ar_if.m_axi_arvalid), 64'd1);
    checkOutput("postrst_araddr", ar_if.m_axi_araddr, 64'h22c0);
    applyStimulus(0, 0, '0, 0, 0);
    checkOutput("postrst_arnext_t4", 64'(arnext), 64'd1);
    applyStimulus(0, 0, '0, 0, 1);
    applyStimulus(0, 0, '0, 0, 0);
    applyStimulus(0, 0, '0, 0, 0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
